// File: rtl/serial_word_receiver.sv
// Serial-in/parallel-out frame receiver: start bit, WIDTH data bits, optional even
// parity, stop bit; the received word is offered on O with a valid/ready handshake.
module serial_word_receiver #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             sin,
    input  logic             sin_en,
    output logic [WIDTH-1:0] O,
    output logic             o_valid,
    input  logic             o_ready,
    output logic             busy,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             par_q, par_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             valid_q, valid_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;

    always_comb begin
        // NOTE: every _d defaults to its _q (pulses to 0) before any branch, so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        word_d  = word_q;
        valid_d = valid_q;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        // A consumer take empties the buffer unless a new word lands on the same edge below.
        if (valid_q && o_ready) begin
            valid_d = 1'b0;
        end

        if (sin_en) begin
            unique case (state_q)
                IDLE: begin
                    if (!sin) begin
                        state_d = DATA;
                        cnt_d   = '0;
                        par_d   = 1'b0;
                    end
                end
                DATA: begin
                    if (MSB_FIRST) begin
                        shift_d = {shift_q[WIDTH-2:0], sin};
                    end else begin
                        shift_d = {sin, shift_q[WIDTH-1:1]};
                    end
                    par_d = par_q ^ sin;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST_BIT) begin
                        cnt_d   = '0;
                        state_d = PARITY_EN ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    par_d   = par_q ^ sin;
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!sin) begin
                        ferr_d = 1'b1;
                    end else if (PARITY_EN && par_q) begin
                        perr_d = 1'b1;
                    end else if (!valid_q || o_ready) begin
                        word_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            word_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every register samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign O          = word_q;
    assign o_valid    = valid_q;
    assign busy       = (state_q != IDLE);
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Bench for serial_word_receiver: one MSB-first and one LSB-first instance share
// the same serial stream; a table of frames plus reset, slow-strobe and back-to-back cases.
module tb_serial_word_receiver;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic       sin = 1'b1;
    logic       sin_en = 1'b0;
    logic       o_ready = 1'b0;
    logic [3:0] O, O_l;
    logic       o_valid, busy, perr, ferr, ovr;
    logic       v_l, b_l, pe_l, fe_l, ov_l;

    int errors = 0;
    int checks = 0;

    serial_word_receiver #(.WIDTH(4), .MSB_FIRST(1'b1), .PARITY_EN(1'b1)) dut_m (
        .clk(clk), .clear(clear), .sin(sin), .sin_en(sin_en),
        .O(O), .o_valid(o_valid), .o_ready(o_ready), .busy(busy),
        .parity_err(perr), .frame_err(ferr), .overrun(ovr)
    );

    serial_word_receiver #(.WIDTH(4), .MSB_FIRST(1'b0), .PARITY_EN(1'b1)) dut_l (
        .clk(clk), .clear(clear), .sin(sin), .sin_en(sin_en),
        .O(O_l), .o_valid(v_l), .o_ready(o_ready), .busy(b_l),
        .parity_err(pe_l), .frame_err(fe_l), .overrun(ov_l)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] word;
        logic       par;
        logic       stop;
        logic       rdy;
        logic       drain;
        logic       load;
        logic [3:0] exp_o;
        logic       exp_v;
        logic       exp_pe;
        logic       exp_fe;
        logic       exp_ov;
    } vec_t;

    typedef struct {
        logic [3:0] m;
        logic [3:0] l;
    } exp_t;

    exp_t exp_q[$];

    function automatic logic [3:0] rev4(input logic [3:0] w);
        return {w[0], w[1], w[2], w[3]};
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    // One strobed bit, preceded by 'gap' unstrobed cycles during which busy must hold.
    task automatic strobe(input logic b, input int gap, input logic exp_busy, input logic rdy);
        for (int g = 0; g < gap; g++) begin
            sin_en = 1'b0;
            @(posedge clk);
            #1;
            check("gap_busy", {3'b0, busy}, {3'b0, exp_busy});
        end
        sin     = b;
        sin_en  = 1'b1;
        o_ready = rdy;
        @(posedge clk);
        #1;
        sin_en  = 1'b0;
        sin     = 1'b1;
        o_ready = 1'b0;
    endtask

    task automatic send_frame(input logic [3:0] w, input logic par, input logic stop,
                              input logic rdy, input int gap);
        strobe(1'b0, gap, 1'b0, 1'b0);
        for (int i = 3; i >= 0; i--) strobe(w[i], gap, 1'b1, 1'b0);
        strobe(par, gap, 1'b1, 1'b0);
        strobe(stop, gap, 1'b1, rdy);
    endtask

    // Called 1 time unit after the stop edge; no clock edge is consumed.
    task automatic check_stop(input string tag, input logic load, input logic [3:0] eo,
                              input logic ev, input logic pe, input logic fe, input logic ov);
        exp_t e;
        if (load) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s_sb: queue empty got O=%b want a queued word", tag, O);
            end else begin
                e = exp_q.pop_front();
                check({tag, "_O"}, O, e.m);
                check({tag, "_Olsb"}, O_l, e.l);
            end
        end else begin
            check({tag, "_O"}, O, eo);
            check({tag, "_Olsb"}, O_l, rev4(eo));
        end
        check({tag, "_valid"}, {3'b0, o_valid}, {3'b0, ev});
        check({tag, "_perr"}, {3'b0, perr}, {3'b0, pe});
        check({tag, "_ferr"}, {3'b0, ferr}, {3'b0, fe});
        check({tag, "_ovr"}, {3'b0, ovr}, {3'b0, ov});
        check({tag, "_busy"}, {3'b0, busy}, 4'd0);
    endtask

    task automatic drain(input string tag, input logic [3:0] eo);
        o_ready = 1'b1;
        @(posedge clk);
        #1;
        o_ready = 1'b0;
        check({tag, "_drain_valid"}, {3'b0, o_valid}, 4'd0);
        check({tag, "_drain_O"}, O, eo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog");
    end

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{4'b1001, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1001, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{4'b1001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1001, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{4'b1001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1001, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{4'b1001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1001, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{4'b1001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1001, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{4'b0110, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1001, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{4'b0110, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{4'b1111, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{4'b1110, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{4'b0001, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1110, 1'b1, 1'b1, 1'b0, 1'b0};

        // Reset state
        #1 clear = 1'b0;
        #1;
        check("rst_O", O, 4'd0);
        check("rst_Olsb", O_l, 4'd0);
        check("rst_valid", {3'b0, o_valid}, 4'd0);
        check("rst_busy", {3'b0, busy}, 4'd0);
        check("rst_pulses", {1'b0, perr, ferr, ovr}, 4'd0);
        @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven frames
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].load) exp_q.push_back('{vecs[i].word, rev4(vecs[i].word)});
            send_frame(vecs[i].word, vecs[i].par, vecs[i].stop, vecs[i].rdy, 0);
            check_stop($sformatf("vec%0d", i), vecs[i].load, vecs[i].exp_o, vecs[i].exp_v,
                       vecs[i].exp_pe, vecs[i].exp_fe, vecs[i].exp_ov);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_pulse_clear", i), {1'b0, perr, ferr, ovr}, 4'd0);
            if (vecs[i].drain) drain($sformatf("vec%0d", i), vecs[i].exp_o);
        end

        // Asynchronous reset in the middle of a frame with a word held
        exp_q.push_back('{4'b0101, 4'b1010});
        send_frame(4'b0101, 1'b0, 1'b1, 1'b0, 0);
        check_stop("pre_rst", 1'b1, 4'b0101, 1'b1, 1'b0, 1'b0, 1'b0);
        strobe(1'b0, 0, 1'b0, 1'b0);
        strobe(1'b1, 0, 1'b1, 1'b0);
        strobe(1'b0, 0, 1'b1, 1'b0);
        #2 clear = 1'b0;
        #1;
        check("midrst_O", O, 4'd0);
        check("midrst_Olsb", O_l, 4'd0);
        check("midrst_valid", {3'b0, o_valid}, 4'd0);
        check("midrst_busy", {3'b0, busy}, 4'd0);
        @(posedge clk);
        #1 clear = 1'b1;
        exp_q.push_back('{4'b1001, 4'b1001});
        send_frame(4'b1001, 1'b0, 1'b1, 1'b0, 0);
        check_stop("post_rst", 1'b1, 4'b1001, 1'b1, 1'b0, 1'b0, 1'b0);
        drain("post_rst", 4'b1001);

        // Strobe every third cycle
        exp_q.push_back('{4'b0111, 4'b1110});
        send_frame(4'b0111, 1'b1, 1'b1, 1'b0, 2);
        check_stop("slow", 1'b1, 4'b0111, 1'b1, 1'b0, 1'b0, 1'b0);

        // Back-to-back frames, each accepted-and-replaced on its stop edge
        exp_q.push_back('{4'b1001, 4'b1001});
        send_frame(4'b1001, 1'b0, 1'b1, 1'b1, 0);
        check_stop("b2b_1", 1'b1, 4'b1001, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_q.push_back('{4'b0110, 4'b0110});
        send_frame(4'b0110, 1'b0, 1'b1, 1'b1, 0);
        check_stop("b2b_2", 1'b1, 4'b0110, 1'b1, 1'b0, 1'b0, 1'b0);
        drain("b2b", 4'b0110);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
